// File: rtl/rob_pkg.sv
// rob_pkg: shared definitions for the reorder buffer and its commit FSM.
//   rob_kind_e  - entry kind as carried on alloc_kind_in (KIND_RSVD commits as REG)
//   ST_SIZE_*   - store size encodings carried in alloc_dest_in[1:0] for STORE entries
//   cm_state_e  - commit FSM state encodings
package rob_pkg;

   typedef enum logic [1:0] {
      KIND_REG    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_STORE  = 2'd2,
      KIND_RSVD   = 2'd3
   } rob_kind_e;

   localparam logic [1:0] ST_SIZE_B = 2'd0;
   localparam logic [1:0] ST_SIZE_H = 2'd1;
   localparam logic [1:0] ST_SIZE_W = 2'd2;

   typedef enum logic {
      CM_IDLE    = 1'b0,
      CM_ST_WAIT = 1'b1
   } cm_state_e;

endpackage

// File: rtl/rob_commit_fsm.sv
// rob_commit_fsm: decodes the head entry, issues at most one commit per cycle,
// runs the store handshake and raises the mispredict flush.
// Ports:
//   clk_in, rst_n_in, rdy_in          clock, async active-low reset, global enable
//   head_*                            fields of the entry at the head pointer
//   st_ready_in                       store acceptance from the memory side
//   commit_fire                       head entry is freed at this edge
//   flush_req                         mispredicting branch commits at this edge
//   cm_*, st_*, bp_*, flush_out,      registered commit / store / predictor /
//   redirect_pc_out                   recovery outputs
//
// state      | meaning
// CM_IDLE    | commit REG/BRANCH at head when ready; launch ready STORE
// CM_ST_WAIT | store presented on st_*; head frozen until st_ready_in
module rob_commit_fsm
   import rob_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             rdy_in,
   input  logic             head_busy,
   input  logic             head_ready,
   input  rob_kind_e        head_kind,
   input  logic [4:0]       head_dest,
   input  logic [XLEN-1:0]  head_pc,
   input  logic [XLEN-1:0]  head_pred,
   input  logic [XLEN-1:0]  head_value,
   input  logic [XLEN-1:0]  head_addr,
   input  logic [TAG_W-1:0] head_tag,
   input  logic             st_ready_in,
   output logic             commit_fire,
   output logic             flush_req,
   output logic             cm_valid_out,
   output logic [4:0]       cm_dest_out,
   output logic [XLEN-1:0]  cm_value_out,
   output logic [TAG_W-1:0] cm_tag_out,
   output logic             st_valid_out,
   output logic [XLEN-1:0]  st_addr_out,
   output logic [XLEN-1:0]  st_data_out,
   output logic [1:0]       st_size_out,
   output logic             bp_valid_out,
   output logic [XLEN-1:0]  bp_pc_out,
   output logic             bp_correct_out,
   output logic             flush_out,
   output logic [XLEN-1:0]  redirect_pc_out
);

   cm_state_e state_q, state_d;
   logic do_reg, do_br, do_st, st_done, mispredict;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= CM_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      do_reg  = 1'b0;
      do_br   = 1'b0;
      do_st   = 1'b0;
      st_done = 1'b0;
      case (state_q)
         CM_IDLE: begin
            if (rdy_in && head_busy && head_ready) begin
               case (head_kind)
                  KIND_STORE: begin
                     do_st   = 1'b1;
                     state_d = CM_ST_WAIT;
                  end
                  KIND_BRANCH: do_br = 1'b1;
                  default:     do_reg = 1'b1;
               endcase
            end
         end
         CM_ST_WAIT: begin
            if (rdy_in && st_ready_in) begin
               st_done = 1'b1;
               state_d = CM_IDLE;
            end
         end
         default: state_d = CM_IDLE;
      endcase
   end

   assign mispredict   = do_br && (head_value != head_pred);
   assign commit_fire  = do_reg | do_br | st_done;
   assign flush_req    = mispredict;
   // st_valid_out comes straight from the state flop, so it stays stable for
   // the whole wait no matter what the head fields do.
   assign st_valid_out = (state_q == CM_ST_WAIT);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cm_valid_out    <= 1'b0;
         cm_dest_out     <= '0;
         cm_value_out    <= '0;
         cm_tag_out      <= '0;
         st_addr_out     <= '0;
         st_data_out     <= '0;
         st_size_out     <= '0;
         bp_valid_out    <= 1'b0;
         bp_pc_out       <= '0;
         bp_correct_out  <= 1'b0;
         flush_out       <= 1'b0;
         redirect_pc_out <= '0;
      end else begin
         cm_valid_out <= do_reg;
         bp_valid_out <= do_br;
         flush_out    <= mispredict;
         if (do_reg) begin
            cm_dest_out  <= head_dest;
            cm_value_out <= head_value;
            cm_tag_out   <= head_tag;
         end
         if (do_br) begin
            bp_pc_out      <= head_pc;
            bp_correct_out <= !mispredict;
         end
         if (mispredict) redirect_pc_out <= head_value;
         if (do_st) begin
            st_addr_out <= head_addr;
            st_data_out <= head_value;
            st_size_out <= head_dest[1:0];
         end
      end
   end

endmodule

// File: rtl/reorder_buffer_param.sv
// reorder_buffer_param: circular reorder buffer with in-order commit of REG,
// BRANCH and STORE entries, multi-port writeback and two operand lookups.
// Ports: allocation (alloc_*), writeback (wb_*), store address (addr_*),
// operand lookup (rd_*), register commit (cm_*), store commit (st_*),
// predictor update (bp_*), recovery (flush_out, redirect_pc_out).
// rdy_in low freezes all state. clk_in rising edge, rst_n_in async active-low.
// Build option: ROB_WB_BYPASS_EN - operand lookup also sees same-cycle
// writebacks; otherwise it reflects registered entry state only.
module reorder_buffer_param
   import rob_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int XLEN   = 32,
   parameter int NUM_WB = 3,
   parameter int TAG_W  = $clog2(DEPTH)
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    rdy_in,
   input  logic                    alloc_valid_in,
   output logic                    alloc_ready_out,
   input  logic [1:0]              alloc_kind_in,
   input  logic [4:0]              alloc_dest_in,
   input  logic [XLEN-1:0]         alloc_pc_in,
   input  logic [XLEN-1:0]         alloc_pred_in,
   output logic [TAG_W-1:0]        alloc_tag_out,
   input  logic [NUM_WB-1:0]       wb_valid_in,
   input  logic [NUM_WB*TAG_W-1:0] wb_tag_in,
   input  logic [NUM_WB*XLEN-1:0]  wb_value_in,
   input  logic                    addr_valid_in,
   input  logic [TAG_W-1:0]        addr_tag_in,
   input  logic [XLEN-1:0]         addr_in,
   input  logic [2*TAG_W-1:0]      rd_tag_in,
   output logic [1:0]              rd_ready_out,
   output logic [2*XLEN-1:0]       rd_value_out,
   output logic                    cm_valid_out,
   output logic [4:0]              cm_dest_out,
   output logic [XLEN-1:0]         cm_value_out,
   output logic [TAG_W-1:0]        cm_tag_out,
   output logic                    st_valid_out,
   input  logic                    st_ready_in,
   output logic [XLEN-1:0]         st_addr_out,
   output logic [XLEN-1:0]         st_data_out,
   output logic [1:0]              st_size_out,
   output logic                    bp_valid_out,
   output logic [XLEN-1:0]         bp_pc_out,
   output logic                    bp_correct_out,
   output logic                    flush_out,
   output logic [XLEN-1:0]         redirect_pc_out
);

   localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

   logic [TAG_W-1:0] head_q, tail_q;
   logic [TAG_W:0]   count_q;
   logic [DEPTH-1:0] busy_q, rdy_q, dok_q, aok_q, ready_vec;
   rob_kind_e        kind_q  [DEPTH];
   logic [4:0]       dest_q  [DEPTH];
   logic [XLEN-1:0]  pc_q    [DEPTH];
   logic [XLEN-1:0]  pred_q  [DEPTH];
   logic [XLEN-1:0]  value_q [DEPTH];
   logic [XLEN-1:0]  addr_q  [DEPTH];
   logic             commit_fire, flush_req, alloc_fire;
   logic [TAG_W-1:0] rt;

   assign alloc_ready_out = (count_q != CNT_FULL);
   assign alloc_tag_out   = tail_q;
   assign alloc_fire      = rdy_in && alloc_valid_in && alloc_ready_out;

   // Stores become ready only once both data and address have arrived.
   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < DEPTH; i++)
         ready_vec[i] = (kind_q[i] == KIND_STORE) ? (dok_q[i] & aok_q[i]) : rdy_q[i];
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         busy_q  <= '0;
         rdy_q   <= '0;
         dok_q   <= '0;
         aok_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            kind_q[i]  <= KIND_REG;
            dest_q[i]  <= '0;
            pc_q[i]    <= '0;
            pred_q[i]  <= '0;
            value_q[i] <= '0;
            addr_q[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (flush_req) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
         end else begin
            // Ascending port order: the highest-index port writes value last.
            for (int p = 0; p < NUM_WB; p++) begin
               if (wb_valid_in[p] && busy_q[wb_tag_in[p*TAG_W +: TAG_W]]) begin
                  value_q[wb_tag_in[p*TAG_W +: TAG_W]] <= wb_value_in[p*XLEN +: XLEN];
                  if (kind_q[wb_tag_in[p*TAG_W +: TAG_W]] == KIND_STORE)
                     dok_q[wb_tag_in[p*TAG_W +: TAG_W]] <= 1'b1;
                  else
                     rdy_q[wb_tag_in[p*TAG_W +: TAG_W]] <= 1'b1;
               end
            end
            if (addr_valid_in && busy_q[addr_tag_in]) begin
               addr_q[addr_tag_in] <= addr_in;
               aok_q[addr_tag_in]  <= 1'b1;
            end
            if (commit_fire) begin
               busy_q[head_q] <= 1'b0;
               head_q         <= head_q + 1'b1;
            end
            if (alloc_fire) begin
               busy_q[tail_q] <= 1'b1;
               rdy_q[tail_q]  <= 1'b0;
               dok_q[tail_q]  <= 1'b0;
               aok_q[tail_q]  <= 1'b0;
               kind_q[tail_q] <= rob_kind_e'(alloc_kind_in);
               dest_q[tail_q] <= alloc_dest_in;
               pc_q[tail_q]   <= alloc_pc_in;
               pred_q[tail_q] <= alloc_pred_in;
               tail_q         <= tail_q + 1'b1;
            end
            count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
         end
      end
   end

   always_comb begin
      rt           = '0;
      rd_ready_out = '0;
      rd_value_out = '0;
      for (int i = 0; i < 2; i++) begin
         rt = rd_tag_in[i*TAG_W +: TAG_W];
         rd_ready_out[i]             = busy_q[rt] & ready_vec[rt];
         rd_value_out[i*XLEN +: XLEN] = value_q[rt];
`ifdef ROB_WB_BYPASS_EN
         for (int p = 0; p < NUM_WB; p++) begin
            if (rdy_in && wb_valid_in[p] && (wb_tag_in[p*TAG_W +: TAG_W] == rt) &&
                busy_q[rt] && (kind_q[rt] != KIND_STORE)) begin
               rd_ready_out[i]             = 1'b1;
               rd_value_out[i*XLEN +: XLEN] = wb_value_in[p*XLEN +: XLEN];
            end
         end
`endif
      end
   end

   rob_commit_fsm #(.XLEN(XLEN), .TAG_W(TAG_W)) u_commit (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .rdy_in          (rdy_in),
      .head_busy       (busy_q[head_q]),
      .head_ready      (ready_vec[head_q]),
      .head_kind       (kind_q[head_q]),
      .head_dest       (dest_q[head_q]),
      .head_pc         (pc_q[head_q]),
      .head_pred       (pred_q[head_q]),
      .head_value      (value_q[head_q]),
      .head_addr       (addr_q[head_q]),
      .head_tag        (head_q),
      .st_ready_in     (st_ready_in),
      .commit_fire     (commit_fire),
      .flush_req       (flush_req),
      .cm_valid_out    (cm_valid_out),
      .cm_dest_out     (cm_dest_out),
      .cm_value_out    (cm_value_out),
      .cm_tag_out      (cm_tag_out),
      .st_valid_out    (st_valid_out),
      .st_addr_out     (st_addr_out),
      .st_data_out     (st_data_out),
      .st_size_out     (st_size_out),
      .bp_valid_out    (bp_valid_out),
      .bp_pc_out       (bp_pc_out),
      .bp_correct_out  (bp_correct_out),
      .flush_out       (flush_out),
      .redirect_pc_out (redirect_pc_out)
   );

endmodule

// File: tb/tb_reorder_buffer_param.sv
module tb_reorder_buffer_param;

   localparam int TW = 4;
   localparam int XL = 32;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic          rdy_in = 1'b1;
   logic          alloc_valid_in = 1'b0;
   logic          alloc_ready_out;
   logic [1:0]    alloc_kind_in = '0;
   logic [4:0]    alloc_dest_in = '0;
   logic [XL-1:0] alloc_pc_in = '0;
   logic [XL-1:0] alloc_pred_in = '0;
   logic [TW-1:0] alloc_tag_out;
   logic [2:0]    wb_valid_in = '0;
   logic [3*TW-1:0] wb_tag_in = '0;
   logic [3*XL-1:0] wb_value_in = '0;
   logic          addr_valid_in = 1'b0;
   logic [TW-1:0] addr_tag_in = '0;
   logic [XL-1:0] addr_in = '0;
   logic [2*TW-1:0] rd_tag_in = '0;
   logic [1:0]    rd_ready_out;
   logic [2*XL-1:0] rd_value_out;
   logic          cm_valid_out;
   logic [4:0]    cm_dest_out;
   logic [XL-1:0] cm_value_out;
   logic [TW-1:0] cm_tag_out;
   logic          st_valid_out;
   logic          st_ready_in = 1'b0;
   logic [XL-1:0] st_addr_out;
   logic [XL-1:0] st_data_out;
   logic [1:0]    st_size_out;
   logic          bp_valid_out;
   logic [XL-1:0] bp_pc_out;
   logic          bp_correct_out;
   logic          flush_out;
   logic [XL-1:0] redirect_pc_out;

   reorder_buffer_param dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .alloc_valid_in(alloc_valid_in), .alloc_ready_out(alloc_ready_out),
      .alloc_kind_in(alloc_kind_in), .alloc_dest_in(alloc_dest_in),
      .alloc_pc_in(alloc_pc_in), .alloc_pred_in(alloc_pred_in),
      .alloc_tag_out(alloc_tag_out),
      .wb_valid_in(wb_valid_in), .wb_tag_in(wb_tag_in), .wb_value_in(wb_value_in),
      .addr_valid_in(addr_valid_in), .addr_tag_in(addr_tag_in), .addr_in(addr_in),
      .rd_tag_in(rd_tag_in), .rd_ready_out(rd_ready_out), .rd_value_out(rd_value_out),
      .cm_valid_out(cm_valid_out), .cm_dest_out(cm_dest_out),
      .cm_value_out(cm_value_out), .cm_tag_out(cm_tag_out),
      .st_valid_out(st_valid_out), .st_ready_in(st_ready_in),
      .st_addr_out(st_addr_out), .st_data_out(st_data_out), .st_size_out(st_size_out),
      .bp_valid_out(bp_valid_out), .bp_pc_out(bp_pc_out), .bp_correct_out(bp_correct_out),
      .flush_out(flush_out), .redirect_pc_out(redirect_pc_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [4:0]    dest;
      logic [XL-1:0] value;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_wb(input int p, input int tag, input logic [XL-1:0] v);
      wb_valid_in[p]          = 1'b1;
      wb_tag_in[p*TW +: TW]   = TW'(tag);
      wb_value_in[p*XL +: XL] = v;
   endtask

   task automatic push_exp(input logic [4:0] d, input logic [XL-1:0] v, input int t);
      exp_t e;
      e.dest  = d;
      e.value = v;
      e.tag   = TW'(t);
      exp_q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      alloc_valid_in = 1'b0;
      wb_valid_in = '0;
      addr_valid_in = 1'b0;
      st_ready_in = 1'b0;
      rd_tag_in = '0;
      tick();
      tick();
      chk("rst_alloc_ready", 64'(alloc_ready_out), 64'd1);
      chk("rst_alloc_tag", 64'(alloc_tag_out), 64'd0);
      chk("rst_cm_valid", 64'(cm_valid_out), 64'd0);
      chk("rst_st_valid", 64'(st_valid_out), 64'd0);
      chk("rst_bp_flush", 64'({bp_valid_out, flush_out}), 64'd0);
      chk("rst_rd", 64'({rd_ready_out, rd_value_out[31:0]}), 64'd0);
      rst_n_in = 1'b1;
      tick();
   endtask

   // Register-commit scoreboard: every cm_valid_out pulse must match the
   // oldest outstanding expectation.
   always begin
      exp_t e;
      @(posedge clk_in);
      #2;
      if (cm_valid_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("cm_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("cm_tag", 64'(cm_tag_out), 64'(e.tag));
            chk("cm_dest", 64'(cm_dest_out), 64'(e.dest));
            chk("cm_value", 64'(cm_value_out), 64'(e.value));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Fill: 16 allocations, no writeback
      for (int n = 0; n < 16; n++) begin
         alloc_valid_in = 1'b1;
         alloc_kind_in  = 2'd0;
         alloc_dest_in  = 5'(n + 10);
         chk("fill_tag", 64'(alloc_tag_out), 64'(n));
         chk("fill_ready", 64'(alloc_ready_out), 64'd1);
         push_exp(5'(n + 10), XL'(32'h100 + n), n);
         tick();
      end
      chk("full_ready", 64'(alloc_ready_out), 64'd0);
      alloc_dest_in = 5'd31;
      tick();
      alloc_valid_in = 1'b0;
      chk("full_ready_17", 64'(alloc_ready_out), 64'd0);
      chk("full_tag_17", 64'(alloc_tag_out), 64'd0);
      for (int i = 0; i < 16; i++) begin
         set_wb(i % 3, i, XL'(32'h100 + i));
         tick();
         wb_valid_in = '0;
         if (i == 0) begin
            chk("rd_ready_tag0", 64'(rd_ready_out[0]), 64'd1);
            chk("rd_value_tag0", 64'(rd_value_out[31:0]), 64'h100);
         end
      end
      drain();

      // Wrap: 40 REG ops, alloc overlapped with writeback and commit
      for (int n = 0; n <= 40; n++) begin
         if (n < 40) begin
            alloc_valid_in = 1'b1;
            alloc_kind_in  = 2'd0;
            alloc_dest_in  = 5'(n % 32);
            chk("wrap_tag", 64'(alloc_tag_out), 64'(n % 16));
            push_exp(5'(n % 32), XL'(n), n % 16);
         end else begin
            alloc_valid_in = 1'b0;
         end
         if (n > 0) set_wb(n % 3, (n - 1) % 16, XL'(n - 1));
         tick();
         wb_valid_in = '0;
      end
      alloc_valid_in = 1'b0;
      drain();

      // Out-of-order writeback: tags 2,0,1
      do_reset();
      for (int n = 0; n < 3; n++) begin
         alloc_valid_in = 1'b1;
         alloc_kind_in  = 2'd0;
         alloc_dest_in  = 5'(n + 5);
         push_exp(5'(n + 5), XL'(32'h20 + n), n);
         tick();
      end
      alloc_valid_in = 1'b0;
      set_wb(0, 2, 32'h22); tick(); wb_valid_in = '0;
      set_wb(1, 0, 32'h20); tick(); wb_valid_in = '0;
      chk("ooo_none_yet", 64'(cm_valid_out), 64'd0);
      set_wb(2, 1, 32'h21); tick(); wb_valid_in = '0;
      chk("ooo_c0", 64'({cm_valid_out, cm_tag_out}), 64'h10);
      tick();
      chk("ooo_c1", 64'({cm_valid_out, cm_tag_out}), 64'h11);
      tick();
      chk("ooo_c2", 64'({cm_valid_out, cm_tag_out}), 64'h12);
      tick();
      chk("ooo_done", 64'(cm_valid_out), 64'd0);
      drain();

      // Branches: one correct (tag 3), one mispredicted (tag 4) with younger REG
      alloc_valid_in = 1'b1; alloc_kind_in = 2'd1;
      alloc_pc_in = 32'h30; alloc_pred_in = 32'h80;
      tick();
      alloc_valid_in = 1'b0;
      set_wb(0, 3, 32'h80); tick(); wb_valid_in = '0;
      tick();
      chk("bp_ok_valid", 64'({bp_valid_out, bp_correct_out, flush_out}), 64'b110);
      chk("bp_ok_pc", 64'(bp_pc_out), 64'h30);
      alloc_valid_in = 1'b1; alloc_kind_in = 2'd1;
      alloc_pc_in = 32'h44; alloc_pred_in = 32'h100;
      tick();
      alloc_kind_in = 2'd0; alloc_dest_in = 5'd9;
      tick();
      alloc_valid_in = 1'b0;
      rd_tag_in[TW-1:0] = 4'd5;
      set_wb(0, 5, 32'h77); tick(); wb_valid_in = '0;
      set_wb(2, 4, 32'h200); tick(); wb_valid_in = '0;
      alloc_valid_in = 1'b1; alloc_kind_in = 2'd0; alloc_dest_in = 5'd12;
      tick();
      alloc_valid_in = 1'b0;
      chk("mp_bp", 64'({bp_valid_out, bp_correct_out}), 64'b10);
      chk("mp_flush", 64'(flush_out), 64'd1);
      chk("mp_redirect", 64'(redirect_pc_out), 64'h200);
      chk("mp_bp_pc", 64'(bp_pc_out), 64'h44);
      chk("mp_tail", 64'({alloc_ready_out, alloc_tag_out}), 64'h10);
      chk("mp_young_gone", 64'(rd_ready_out[0]), 64'd0);
      tick();
      chk("mp_pulse_end", 64'({bp_valid_out, flush_out}), 64'd0);

      // Store: data then address, st_ready_in low for 5 cycles
      alloc_valid_in = 1'b1; alloc_kind_in = 2'd2; alloc_dest_in = 5'd2;
      tick();
      alloc_kind_in = 2'd0; alloc_dest_in = 5'd3;
      push_exp(5'd3, 32'h33, 1);
      tick();
      alloc_valid_in = 1'b0;
      set_wb(1, 1, 32'h33); tick(); wb_valid_in = '0;
      set_wb(0, 0, 32'hDEAD_BEEF); tick(); wb_valid_in = '0;
      tick();
      chk("st_wait_addr", 64'({st_valid_out, cm_valid_out}), 64'd0);
      addr_valid_in = 1'b1; addr_tag_in = 4'd0; addr_in = 32'h1000;
      tick();
      addr_valid_in = 1'b0;
      chk("st_not_yet", 64'(st_valid_out), 64'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("st_valid", 64'(st_valid_out), 64'd1);
         chk("st_addr", 64'(st_addr_out), 64'h1000);
         chk("st_data", 64'(st_data_out), 64'hDEAD_BEEF);
         chk("st_size", 64'(st_size_out), 64'd2);
         chk("st_no_younger", 64'(cm_valid_out), 64'd0);
         if (i == 5) st_ready_in = 1'b1;
         tick();
      end
      st_ready_in = 1'b0;
      chk("st_released", 64'(st_valid_out), 64'd0);
      drain();

      // rdy_in low freezes allocation; then bypass and port priority
      do_reset();
      rdy_in = 1'b0;
      alloc_valid_in = 1'b1; alloc_kind_in = 2'd0; alloc_dest_in = 5'd1;
      tick();
      chk("frozen_tag", 64'(alloc_tag_out), 64'd0);
      rdy_in = 1'b1;
      for (int n = 0; n < 4; n++) begin
         alloc_dest_in = 5'(n + 1);
         tick();
      end
      alloc_valid_in = 1'b0;
      push_exp(5'd1, 32'hA, 0);
      push_exp(5'd2, 32'hB, 1);
      push_exp(5'd3, 32'h22, 2);
      push_exp(5'd4, 32'h55, 3);
      rd_tag_in = {4'd3, 4'd8};
      set_wb(1, 3, 32'h55);
      set_wb(2, 8, 32'h99);
      #1;
`ifdef ROB_WB_BYPASS_EN
      chk("byp_ready", 64'(rd_ready_out[1]), 64'd1);
      chk("byp_value", 64'(rd_value_out[63:32]), 64'h55);
`else
      chk("byp_ready", 64'(rd_ready_out[1]), 64'd0);
`endif
      tick();
      wb_valid_in = '0;
      chk("reg_ready", 64'(rd_ready_out[1]), 64'd1);
      chk("reg_value", 64'(rd_value_out[63:32]), 64'h55);
      chk("idle_wb_ignored", 64'(rd_ready_out[0]), 64'd0);
      set_wb(0, 2, 32'h11);
      set_wb(2, 2, 32'h22);
      tick();
      wb_valid_in = '0;
      set_wb(1, 1, 32'hB); tick(); wb_valid_in = '0;
      set_wb(0, 0, 32'hA); tick(); wb_valid_in = '0;
      drain();
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
